// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter.
// FSM encodings, requester ids and the default window base.
package dmem_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h1001_0000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick.
// On a tie the requester that was not served last wins.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       id_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = M0;
    unique case (req_i)
      2'b11:   id_o = ~last_i;
      2'b10:   id_o = M1;
      default: id_o = M0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the load/store path (m0) and a loader/DMA (m1).
// Each transaction takes an ISSUE cycle then a RESP cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          DEPTH     = 1024,
  parameter int          AW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic          m0_err,
  output logic [31:0]   m0_rdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic          m1_err,
  output logic [31:0]   m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [31:0] LIM = 32'(DEPTH) << 2;

  logic [1:0]  state_q, state_d;
  logic        last_q;
  logic        id_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        pick_id;
  logic        pick_v;
  logic        decide;
  logic        issue;
  logic        resp;
  logic [31:0] off;
  logic        ok;

  rr_arbiter2 u_rr (
    .req_i   ({m1_req, m0_req}),
    .last_i  (last_q),
    .id_o    (pick_id),
    .valid_o (pick_v)
  );

  assign issue  = (state_q == S_ISSUE);
  assign resp   = (state_q == S_RESP);
  assign decide = pick_v & ((state_q == S_IDLE) | resp);

  // Modular subtraction folds below-window addresses into huge offsets.
  assign off = addr_q - BASE_ADDR;
  assign ok  = (off < LIM) & (addr_q[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_v) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = pick_v ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= M1;
      id_q    <= M0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (decide) begin
        last_q  <= pick_id;
        id_q    <= pick_id;
        we_q    <= pick_id ? m1_we    : m0_we;
        addr_q  <= pick_id ? m1_addr  : m0_addr;
        wdata_q <= pick_id ? m1_wdata : m0_wdata;
      end
      if (issue)
        rdata_q <= (ok & ~we_q) ? mem_rdata : '0;
    end
  end

  assign m0_gnt    = issue & (id_q == M0);
  assign m1_gnt    = issue & (id_q == M1);
  assign mem_we    = issue & we_q & ok & ~reset;
  assign mem_re    = issue & ~we_q & ok & ~reset;
  assign mem_addr  = issue ? off[AW+1:2] : '0;
  assign mem_wdata = issue ? wdata_q : '0;

  assign m0_done  = resp & (id_q == M0);
  assign m1_done  = resp & (id_q == M1);
  assign m0_err   = m0_done & ~ok;
  assign m1_err   = m1_done & ~ok;
  assign m0_rdata = m0_done ? rdata_q : '0;
  assign m1_rdata = m1_done ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we, mem_re;
  logic [31:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic tb_init;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'hDEAD_BEEF : {16'h5555, 16'(i)};
  endfunction

  function automatic logic in_window(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (o < 32'(DEPTH * 4)) && (a % 4 == 0);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2) % DEPTH;
  endfunction

  // Memory attached to the DUT
  logic [31:0] mem [DEPTH];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (tb_init)
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    else if (mem_we)
      mem[mem_addr] <= mem_wdata;
  end

  // Reference model: one pending transaction, phase 0 none / 1 issue / 2 resp
  logic [31:0] ref_mem [DEPTH];
  int          m_phase;
  logic        m_id, m_we, m_last, m_win;
  logic [31:0] m_addr, m_wd, m_rd;

  always_comb begin
    m_win = 1'b0;
    if (m0_req && m1_req) m_win = ~m_last;
    else if (m1_req)      m_win = 1'b1;
  end

  always @(posedge clk) begin
    if (tb_init)
      for (int i = 0; i < DEPTH; i++) ref_mem[i] <= init_word(i);
    if (reset) begin
      m_phase <= 0;
      m_last  <= 1'b1;
      m_id    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wd    <= '0;
      m_rd    <= '0;
    end else if (m_phase == 1) begin
      m_phase <= 2;
      m_rd <= (in_window(m_addr) && !m_we) ? ref_mem[word_of(m_addr)] : 32'h0;
      if (in_window(m_addr) && m_we) ref_mem[word_of(m_addr)] <= m_wd;
    end else if (m0_req || m1_req) begin
      m_phase <= 1;
      m_id    <= m_win;
      m_last  <= m_win;
      m_we    <= m_win ? m1_we : m0_we;
      m_addr  <= m_win ? m1_addr : m0_addr;
      m_wd    <= m_win ? m1_wdata : m0_wdata;
    end else begin
      m_phase <= 0;
    end
  end

  logic        e_g0, e_g1, e_d0, e_d1, e_e0, e_e1, e_we, e_re;
  logic [31:0] e_r0, e_r1, e_wd;
  logic [9:0]  e_addr;

  always_comb begin
    e_g0 = 1'b0; e_g1 = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
    e_e0 = 1'b0; e_e1 = 1'b0; e_we = 1'b0; e_re = 1'b0;
    e_r0 = '0; e_r1 = '0; e_wd = '0; e_addr = '0;
    if (m_phase == 1) begin
      e_g0   = !m_id;
      e_g1   = m_id;
      e_we   = m_we && in_window(m_addr) && !reset;
      e_re   = !m_we && in_window(m_addr) && !reset;
      e_addr = 10'(word_of(m_addr));
      e_wd   = m_wd;
    end else if (m_phase == 2) begin
      e_d0 = !m_id;
      e_d1 = m_id;
      e_e0 = !m_id && !in_window(m_addr);
      e_e1 = m_id && !in_window(m_addr);
      e_r0 = m_id ? 32'h0 : m_rd;
      e_r1 = m_id ? m_rd : 32'h0;
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("m0_gnt", m0_gnt, e_g0);
      chk1("m1_gnt", m1_gnt, e_g1);
      chk1("m0_done", m0_done, e_d0);
      chk1("m1_done", m1_done, e_d1);
      chk1("m0_err", m0_err, e_e0);
      chk1("m1_err", m1_err, e_e1);
      chk32("m0_rdata", m0_rdata, e_r0);
      chk32("m1_rdata", m1_rdata, e_r1);
      chk1("mem_we", mem_we, e_we);
      chk1("mem_re", mem_re, e_re);
      chk32("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk32("mem_wdata", mem_wdata, e_wd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit m, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] wd);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd;
    end else begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd;
    end
  endtask

  // One transaction from IDLE; reports latencies and what the memory saw.
  task automatic xact(input bit m, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lg, output int ld,
                      output logic mwe, output logic mre, output logic [9:0] ma);
    rd = '0; er = 1'b0; lg = -1; ld = -1; mwe = 1'b0; mre = 1'b0; ma = '0;
    drive(m, 1'b1, we, a, wd);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (m ? m1_gnt : m0_gnt) begin
        lg = c; mwe = mem_we; mre = mem_re; ma = mem_addr;
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (m ? m1_done : m0_done) begin
        ld = c;
        rd = m ? m1_rdata : m0_rdata;
        er = m ? m1_err : m0_err;
        break;
      end
    end
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  logic [31:0] rd;
  logic        er, mwe, mre;
  logic [9:0]  ma;
  int          lg, ld;
  int          order [4];
  int          tg [4];
  int          ng, both, m0g, diffs;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; tb_init = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    tb_init = 1'b0;
    chk_en  = 1'b1;
    step();
    chk32("reset_outputs",
          {20'h0, m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err,
           mem_we, mem_re, |mem_addr, |mem_wdata, |m0_rdata, |m1_rdata},
          32'h0);
    reset = 1'b0;

    // single m0 read of word 2
    xact(1'b0, 1'b0, 32'h1001_0008, 32'h0, rd, er, lg, ld, mwe, mre, ma);
    chk32("t1_gnt_lat", 32'(lg), 32'd1);
    chk32("t1_done_lat", 32'(ld), 32'd2);
    chk1("t1_mem_re", mre, 1'b1);
    chk32("t1_mem_addr", 32'(ma), 32'd2);
    chk32("t1_rdata", rd, 32'hDEAD_BEEF);
    chk1("t1_err", er, 1'b0);

    // m1 write to the top word, then m0 reads it back
    xact(1'b1, 1'b1, 32'h1001_0FFC, 32'h0000_00A5, rd, er, lg, ld, mwe, mre, ma);
    chk1("t2_mem_we", mwe, 1'b1);
    chk32("t2_mem_addr", 32'(ma), 32'd1023);
    chk32("t2_done_lat", 32'(ld), 32'd2);
    xact(1'b0, 1'b0, 32'h1001_0FFC, 32'h0, rd, er, lg, ld, mwe, mre, ma);
    chk32("t2_readback", rd, 32'h0000_00A5);

    // both masters saturating from reset
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h1001_0004, 32'h0);
    step();
    reset = 1'b0;
    ng = 0; both = 0;
    for (int c = 1; c <= 12 && ng < 4; c++) begin
      step();
      if (m0_gnt && m1_gnt) both++;
      if (m0_gnt || m1_gnt) begin
        order[ng] = m1_gnt ? 1 : 0;
        tg[ng] = c;
        ng++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(); step(); step();
    chk32("t3_grants", 32'(ng), 32'd4);
    chk32("t3_order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]},
          32'h0001_0001);
    chk32("t3_first_gnt", 32'(tg[0]), 32'd1);
    chk32("t3_spacing", {tg[1][7:0] - tg[0][7:0], tg[2][7:0] - tg[1][7:0],
                         tg[3][7:0] - tg[2][7:0], 8'd0}, 32'h0202_0200);
    chk32("t3_both_gnt", 32'(both), 32'd0);

    // out-of-window read, misaligned write
    xact(1'b0, 1'b0, 32'h1001_1000, 32'h0, rd, er, lg, ld, mwe, mre, ma);
    chk1("t4a_err", er, 1'b1);
    chk32("t4a_rdata", rd, 32'h0);
    chk1("t4a_no_mem", mwe | mre, 1'b0);
    chk32("t4a_gnt_lat", 32'(lg), 32'd1);
    xact(1'b1, 1'b1, 32'h1001_0002, 32'hFFFF_FFFF, rd, er, lg, ld, mwe, mre, ma);
    chk1("t4b_err", er, 1'b1);
    chk32("t4b_rdata", rd, 32'h0);
    chk1("t4b_no_mem", mwe | mre, 1'b0);
    chk32("t4b_word0", mem[0], 32'h5555_0000);

    // reset lands on the ISSUE cycle of a write to word 5
    drive(1'b1, 1'b1, 1'b1, 32'h1001_0014, 32'h0000_1234);
    step();
    chk1("t5_gnt", m1_gnt, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    chk1("t5_we_blocked", mem_we, 1'b0);
    step();
    reset = 1'b0;
    chk32("t5_outputs_clear",
          {20'h0, m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err,
           mem_we, mem_re, |mem_addr, |mem_wdata, |m0_rdata, |m1_rdata},
          32'h0);
    step();
    chk1("t5_no_done", m1_done, 1'b0);
    chk32("t5_word5", mem[5], 32'h5555_0005);

    // m0 pulses req while m1 is in flight and must never be granted
    drive(1'b1, 1'b1, 1'b1, 32'h1001_001C, 32'h0000_0077);
    step();
    chk1("t6_m1_gnt", m1_gnt, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h1001_0008, 32'h0);
    step();
    chk1("t6_m1_done", m1_done, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    m0g = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (m0_gnt) m0g++;
    end
    chk32("t6_m0_grants", 32'(m0g), 32'd0);
    chk32("t6_word7", mem[7], 32'h0000_0077);

    diffs = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    chk32("final_mem_diffs", 32'(diffs), 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
